inst_injector: RTL and testbench
================================

// Module: inst_injector
// PURPOSE
//  Command-to-instruction encoder for the debug/boot path. It takes high-level
//  debug commands (load immediate, load word, store word, CSR read/write,
//  jump, nop) and emits legal RV32I instruction words, which are muxed into the
//  fetch stage ahead of the control decoder. It uses a valid/ready handshake
//  on both sides, and 32-bit immediates expand to LUI+ADDI.
// PARAMETERS
//  XLEN       32  instruction/data width; only 32 is supported
//  CNT_WIDTH  16  width of the emitted-instruction counter
// PORTS
//  clk        in   1          clock, rising edge
//  reset      in   1          asynchronous, active-high reset
//  cmd_valid  in   1          command present
//  cmd_ready  out  1          command accepted when cmd_valid & cmd_ready
//  cmd_op     in   3          0 LI,1 LW,2 SW,3 CSRR,4 CSRW,5 JALR,6 NOP,7 rsvd
//  cmd_rd     in   5          destination reg (LI/LW/CSRR); data reg rs2 (SW)
//  cmd_rs     in   5          base reg (LW/SW/JALR); source reg (CSRW)
//  cmd_imm    in   XLEN       immediate/offset; CSR address in [11:0]
//  inst_valid out  1          inst holds a valid instruction
//  inst_ready in   1          fetch consumes inst when inst_valid & inst_ready
//  inst       out  XLEN       encoded instruction word
//  busy       out  1          state != IDLE
//  error      out  1          one-cycle pulse: the command was rejected
//  inst_count out  CNT_WIDTH  number of instructions handed off, wraps
// BEHAVIOUR
//  Reset (asynchronous, takes effect immediately): state=IDLE, inst_valid=0,
//   inst=0, error=0, inst_count=0. A reset mid-sequence drops any pending
//   second instruction.
//  FSM IDLE -> FIRST -> [SECOND] -> IDLE; cmd_ready = (state==IDLE).
//  IDLE: on accept, encode into registers. Next cycle: state=FIRST and
//   inst_valid=1, so latency is 1 cycle. Rejected commands stay in IDLE and
//   pulse error for 1 cycle with no instruction emitted.
//  FIRST/SECOND: inst is held stable while inst_ready=0. On handshake,
//   inst_count+=1 (mod 2^CNT_WIDTH). FIRST goes to SECOND if a second word is
//   pending, else to IDLE. SECOND goes to IDLE.
//  After the last handshake, inst_valid=0 for 1 cycle (IDLE); no back-to-back
//   commands.
//  Encodings (x0 = reg 0):
//   LI: if imm fits signed 12b -> ADDI rd,x0,imm[11:0]. Otherwise
//    hi=(imm+0x800)>>12 (mod 2^32) and lo=imm[11:0]. Emit LUI rd,hi, then
//    ADDI rd,rd,lo; the ADDI is omitted when lo==0.
//   LW: LW rd,imm(rs). SW: SW rd,imm(rs) (S-type split immediate).
//   JALR: JALR x0,rs,imm. For LW, SW and JALR, an imm outside the signed 12b
//    range -> error.
//   CSRR: CSRRS rd,imm[11:0],x0. CSRW: CSRRW x0,imm[11:0],rs. imm[31:12] is
//    ignored.
//   NOP: ADDI x0,x0,0 = 0x00000013. op 7 -> error.
//  Inputs are sampled only at accept; later changes to cmd_* have no effect.
// TESTING
//  LI x3,0xFFFFFFFF -> single word 0xFFF00193; inst_count=1.
//  LI x5,0x12345678 -> 0x123452B7 then 0x67828293; busy until 2nd handshake.
//  LI x1,0x800 -> 0x000010B7, 0x80008093; LI x4,0x10000 -> 0x00010237 only.
//  SW x6,8(x2) -> 0x00612423; CSRR x7,0xC00 -> 0xC00023F3.
//  LW imm=0x1000 and op=7 -> error pulse 1 cycle, inst_valid stays 0, count
//   unchanged.
//  inst_ready=0 for 5 cycles mid-LI -> inst stable; reset in SECOND ->
//   inst_valid=0 at once, IDLE, count=0.

Source files
------------

// File: rtl/inst_injector.sv
// Debug/boot command encoder: turns high-level debug commands into RV32I
// instruction words and hands them to fetch over a valid/ready handshake.
// 32-bit load-immediates that do not fit in 12 bits expand to LUI+ADDI.
module inst_injector #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [4:0]           cmd_rd,
  input  logic [4:0]           cmd_rs,
  input  logic [XLEN-1:0]      cmd_imm,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [XLEN-1:0]      inst,
  output logic                 busy,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] inst_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FIRST  = 2'd1;
  localparam logic [1:0] SECOND = 2'd2;

  localparam logic [2:0] OP_LI   = 3'd0;
  localparam logic [2:0] OP_LW   = 3'd1;
  localparam logic [2:0] OP_SW   = 3'd2;
  localparam logic [2:0] OP_CSRR = 3'd3;
  localparam logic [2:0] OP_CSRW = 3'd4;
  localparam logic [2:0] OP_JALR = 3'd5;
  localparam logic [2:0] OP_NOP  = 3'd6;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic [1:0]           state_q, state_d;
  logic [XLEN-1:0]      inst_q, inst_d;
  logic [XLEN-1:0]      inst2_q, inst2_d;
  logic                 has2_q, has2_d;
  logic                 error_q, error_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic            fits12;
  logic [11:0]     imm12;
  logic [19:0]     hi20;
  logic [XLEN-1:0] enc_w0, enc_w1;
  logic            enc_two, enc_err;
  logic            handshake;

  assign imm12  = cmd_imm[11:0];
  assign fits12 = (cmd_imm[31:11] == '0) || (cmd_imm[31:11] == '1);
  // Upper part rounded so that the sign-extended ADDI low part lands exactly.
  assign hi20   = cmd_imm[31:12] + {19'b0, cmd_imm[11]};

  // Encode the command currently on the inputs into one or two words.
  always_comb begin
    enc_w0  = '0;
    enc_w1  = '0;
    enc_two = 1'b0;
    enc_err = 1'b0;
    case (cmd_op)
      OP_LI: begin
        if (fits12) begin
          enc_w0 = {imm12, 5'd0, 3'b000, cmd_rd, OPC_OPIMM};
        end else begin
          enc_w0  = {hi20, cmd_rd, OPC_LUI};
          enc_w1  = {imm12, cmd_rd, 3'b000, cmd_rd, OPC_OPIMM};
          enc_two = (imm12 != '0);
        end
      end
      OP_LW: begin
        enc_w0  = {imm12, cmd_rs, 3'b010, cmd_rd, OPC_LOAD};
        enc_err = !fits12;
      end
      OP_SW: begin
        enc_w0  = {imm12[11:5], cmd_rd, cmd_rs, 3'b010, imm12[4:0], OPC_STORE};
        enc_err = !fits12;
      end
      OP_CSRR: enc_w0 = {imm12, 5'd0, 3'b010, cmd_rd, OPC_SYSTEM};
      OP_CSRW: enc_w0 = {imm12, cmd_rs, 3'b001, 5'd0, OPC_SYSTEM};
      OP_JALR: begin
        enc_w0  = {imm12, cmd_rs, 3'b000, 5'd0, OPC_JALR};
        enc_err = !fits12;
      end
      OP_NOP:  enc_w0 = {12'd0, 5'd0, 3'b000, 5'd0, OPC_OPIMM};
      default: enc_err = 1'b1;
    endcase
  end

  assign handshake = (state_q != IDLE) && inst_ready;

  // Next-state logic: accept in IDLE, then hand off one or two words.
  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    inst2_d = inst2_q;
    has2_d  = has2_q;
    error_d = 1'b0;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (enc_err) begin
            error_d = 1'b1;
          end else begin
            inst_d  = enc_w0;
            inst2_d = enc_w1;
            has2_d  = enc_two;
            state_d = FIRST;
          end
        end
      end
      FIRST: begin
        if (handshake) begin
          count_d = count_q + CNT_WIDTH'(1);
          if (has2_q) begin
            inst_d  = inst2_q;
            state_d = SECOND;
          end else begin
            state_d = IDLE;
          end
        end
      end
      SECOND: begin
        if (handshake) begin
          count_d = count_q + CNT_WIDTH'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous reset; reset drops any pending word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      inst_q  <= '0;
      inst2_q <= '0;
      has2_q  <= 1'b0;
      error_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      inst2_q <= inst2_d;
      has2_q  <= has2_d;
      error_q <= error_d;
      count_q <= count_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign inst_valid = (state_q != IDLE);
  assign busy       = (state_q != IDLE);
  assign inst       = inst_q;
  assign error      = error_q;
  assign inst_count = count_q;

endmodule

// File: tb/tb_inst_injector.sv
// Bench for inst_injector: queue-based reference model checked every cycle,
// directed literal cases, stall and mid-sequence reset, then random commands.
module tb_inst_injector;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = '0;
  logic [4:0]  cmd_rd = '0;
  logic [4:0]  cmd_rs = '0;
  logic [31:0] cmd_imm = '0;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic        busy;
  logic        error;
  logic [15:0] inst_count;

  int unsigned rnd = 0;
  int unsigned rdy_pct = 100;
  assign inst_ready = (rnd < rdy_pct);

  inst_injector #(.XLEN(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_imm(cmd_imm),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .busy(busy), .error(error), .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 rnd = $urandom_range(0, 99);
  end

  int n_checks = 0;
  int n_err = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Reference encoder from the instruction-format rules, plain arithmetic.
  function automatic void model_encode(input logic [2:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [31:0] imm,
                                       output bit err, output int n,
                                       output logic [31:0] a, output logic [31:0] b);
    int unsigned urd, urs, i12, hi, lo;
    bit fits;
    urd  = rd;
    urs  = rs;
    i12  = imm & 32'hFFF;
    fits = ($signed(imm) >= -2048) && ($signed(imm) <= 2047);
    err  = 0;
    n    = 1;
    a    = 0;
    b    = 0;
    case (op)
      3'd0: begin
        if (fits) a = (i12 << 20) + (urd << 7) + 19;
        else begin
          hi = (imm + 32'h800) >> 12;
          lo = i12;
          a  = (hi << 12) + (urd << 7) + 55;
          if (lo != 0) begin
            n = 2;
            b = (lo << 20) + (urd << 15) + (urd << 7) + 19;
          end
        end
      end
      3'd1: begin err = !fits; a = (i12 << 20) + (urs << 15) + (2 << 12) + (urd << 7) + 3; end
      3'd2: begin
        err = !fits;
        a = ((i12 >> 5) << 25) + (urd << 20) + (urs << 15) + (2 << 12) + ((i12 & 31) << 7) + 35;
      end
      3'd3: a = (i12 << 20) + (2 << 12) + (urd << 7) + 115;
      3'd4: a = (i12 << 20) + (urs << 15) + (1 << 12) + 115;
      3'd5: begin err = !fits; a = (i12 << 20) + (urs << 15) + 103; end
      3'd6: a = 32'h13;
      default: err = 1;
    endcase
    if (err) n = 0;
  endfunction

  // Model state: words still to hand off, pending error pulse, handoff count.
  logic [31:0] mq[$];
  bit          m_err = 0;
  int unsigned m_cnt = 0;

  always @(posedge clk) begin
    bit e; int n; logic [31:0] a, b;
    if (!reset) begin
      m_err = 0;
      if (mq.size() != 0) begin
        if (inst_ready) begin
          void'(mq.pop_front());
          m_cnt++;
        end
      end else if (cmd_valid) begin
        model_encode(cmd_op, cmd_rd, cmd_rs, cmd_imm, e, n, a, b);
        if (e) m_err = 1;
        else begin
          mq.push_back(a);
          if (n == 2) mq.push_back(b);
        end
      end
    end
  end

  logic [31:0] got[$];
  int          err_seen = 0;

  // Per-cycle compare against the model, plus a record of handed-off words.
  always @(negedge clk) begin
    if (!reset) begin
      chk("cmd_ready", cmd_ready, mq.size() == 0);
      chk("inst_valid", inst_valid, mq.size() != 0);
      chk("busy", busy, mq.size() != 0);
      chk("error", error, m_err);
      chk("inst_count", inst_count, m_cnt & 32'hFFFF);
      if (mq.size() != 0) chk("inst", inst, mq[0]);
      if (inst_valid && inst_ready) got.push_back(inst);
      if (error) err_seen++;
    end
  end

  task automatic issue(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [31:0] imm);
    int t;
    @(posedge clk); #1;
    cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_imm = imm; cmd_valid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!cmd_ready && t < 100);
    if (!cmd_ready) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    // Scramble inputs after accept: they must not influence the result.
    cmd_valid = 1'b0;
    cmd_op = 3'($urandom); cmd_rd = 5'($urandom); cmd_rs = 5'($urandom); cmd_imm = $urandom;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (!cmd_ready && t < 400);
    if (!cmd_ready) chk("idle_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic dir(input string nm, input logic [2:0] op, input logic [4:0] rd,
                     input logic [4:0] rs, input logic [31:0] imm, input int en,
                     input logic [31:0] e0, input logic [31:0] e1, input int eerr);
    logic [15:0] c0;
    c0 = inst_count;
    got.delete();
    err_seen = 0;
    issue(op, rd, rs, imm);
    wait_idle();
    chk({nm, "_nwords"}, got.size(), en);
    if (en > 0 && got.size() > 0) chk({nm, "_w0"}, got[0], e0);
    if (en > 1 && got.size() > 1) chk({nm, "_w1"}, got[1], e1);
    chk({nm, "_errpulses"}, err_seen, eerr);
    chk({nm, "_count"}, inst_count, c0 + 16'(en));
  endtask

  logic [31:0] bnd[10] = '{32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF, 32'd0,
                           32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h00000800, 32'hFFFFF000};

  initial begin
    logic [31:0] imm;
    rdy_pct = 100;
    #1 reset = 1'b1;
    #10;
    chk("rst_inst", inst, 32'h0);
    chk("rst_valid", inst_valid, 32'd0);
    chk("rst_count", inst_count, 32'd0);
    chk("rst_error", error, 32'd0);
    chk("rst_ready", cmd_ready, 32'd1);
    @(negedge clk); #2 reset = 1'b0;

    dir("li_m1", 3'd0, 5'd3, 5'd0, 32'hFFFFFFFF, 1, 32'hFFF00193, 32'h0, 0);
    chk("count_after_first", inst_count, 32'd1);
    dir("li_big", 3'd0, 5'd5, 5'd9, 32'h12345678, 2, 32'h123452B7, 32'h67828293, 0);
    dir("li_800", 3'd0, 5'd1, 5'd0, 32'h00000800, 2, 32'h000010B7, 32'h80008093, 0);
    dir("li_10000", 3'd0, 5'd4, 5'd0, 32'h00010000, 1, 32'h00010237, 32'h0, 0);
    dir("sw", 3'd2, 5'd6, 5'd2, 32'd8, 1, 32'h00612423, 32'h0, 0);
    dir("csrr", 3'd3, 5'd7, 5'd11, 32'hABCDEC00, 1, 32'hC00023F3, 32'h0, 0);
    dir("lw_neg", 3'd1, 5'd1, 5'd2, 32'hFFFFF800, 1, 32'h80012083, 32'h0, 0);
    dir("nop", 3'd6, 5'd9, 5'd9, 32'h5, 1, 32'h00000013, 32'h0, 0);
    dir("lw_err", 3'd1, 5'd1, 5'd2, 32'h00001000, 0, 32'h0, 32'h0, 1);
    dir("op7_err", 3'd7, 5'd1, 5'd2, 32'h0, 0, 32'h0, 32'h0, 1);
    dir("jalr_err", 3'd5, 5'd0, 5'd1, 32'd2048, 0, 32'h0, 32'h0, 1);

    // Stall: first LI word must hold while fetch is not ready.
    got.delete();
    rdy_pct = 0;
    issue(3'd0, 5'd5, 5'd0, 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_inst", inst, 32'h123452B7);
      chk("stall_valid", inst_valid, 32'd1);
    end
    rdy_pct = 100;
    wait_idle();
    chk("stall_nwords", got.size(), 32'd2);

    // Reset while the second word is pending.
    rdy_pct = 0;
    issue(3'd0, 5'd5, 5'd0, 32'h12345678);
    @(negedge clk);
    rdy_pct = 100;
    @(posedge clk); #2 rdy_pct = 0;
    @(negedge clk);
    chk("second_inst", inst, 32'h67828293);
    #1 reset = 1'b1;
    #1;
    chk("midrst_valid", inst_valid, 32'd0);
    chk("midrst_busy", busy, 32'd0);
    chk("midrst_count", inst_count, 32'd0);
    chk("midrst_ready", cmd_ready, 32'd1);
    chk("midrst_inst", inst, 32'h0);
    mq.delete(); m_cnt = 0; m_err = 0;
    @(negedge clk); #2 reset = 1'b0;
    rdy_pct = 100;

    // Random commands with random fetch back-pressure.
    for (int k = 0; k < 250; k++) begin
      rdy_pct = $urandom_range(30, 100);
      case ($urandom_range(0, 4))
        0: imm = $urandom;
        1: imm = 32'($signed($urandom_range(0, 4095)) - 2048);
        2: imm = bnd[$urandom_range(0, 9)];
        3: imm = $urandom << 12;
        default: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      endcase
      issue(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), imm);
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
